// File: rtl/ppfm_pkg.sv
// Shared types and Q1.15 helpers for the partial-FM channel scheduler.
// Holds the scheduler state encoding and the saturating 16-bit add.
package ppfm_pkg;

    localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Sign-extend both operands to 17 bits; the top two sum bits disagree only on overflow.
    function automatic logic [15:0] sat16_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        case (s[16:15])
            2'b01:   sat16_add = Q_MAX;
            2'b10:   sat16_add = Q_MIN;
            default: sat16_add = s[15:0];
        endcase
    endfunction

endpackage

// File: rtl/ppfm_sat_accum.sv
// Multi-lane 16-bit Q1.15 accumulator: clear, load or saturating add per cycle.
// One instance accumulates one kernel's partial FM across channels.
module ppfm_sat_accum
    import ppfm_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  add,
    input  logic [16*LANES-1:0]   din,
    output logic [16*LANES-1:0]   acc
);

    // clear wins over load, load wins over add
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= din;
        end else if (add) begin
            for (int n = 0; n < LANES; n++) begin
                acc[16*n +: 16] <= sat16_add(acc[16*n +: 16], din[16*n +: 16]);
            end
        end
    end

endmodule

// File: rtl/ppfm_channel_scheduler.sv
// Sequences the partial-FM engine over the channels of one layer and sums the partials.
// Handshakes: a transfer happens on the rising clk edge where valid && ready are both 1.
module ppfm_channel_scheduler
    import ppfm_pkg::*;
#(
    parameter int IP_SIZE     = 6,
    parameter int KERNEL_SIZE = 3,
    parameter int OP_SIZE     = IP_SIZE - KERNEL_SIZE + 1,
    parameter int MAX_CH      = 16,
    parameter int TIMEOUT     = 64,
    localparam int IPW        = 16 * IP_SIZE * IP_SIZE,
    localparam int KW         = 16 * KERNEL_SIZE * KERNEL_SIZE,
    localparam int OPW        = 16 * OP_SIZE * OP_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ch_valid,
    output logic            ch_ready,
    input  logic            ch_last,
    input  logic [IPW-1:0]  ch_ipf,
    input  logic [KW-1:0]   ch_K1f,
    input  logic [KW-1:0]   ch_K2f,
    input  logic [KW-1:0]   ch_K3f,
    output logic            eng_rst,
    output logic [IPW-1:0]  eng_ipf,
    output logic [KW-1:0]   eng_K1f,
    output logic [KW-1:0]   eng_K2f,
    output logic [KW-1:0]   eng_K3f,
    input  logic            eng_resting,
    input  logic [OPW-1:0]  eng_IK1,
    input  logic [OPW-1:0]  eng_IK2,
    input  logic [OPW-1:0]  eng_IK3,
    output logic            fm_valid,
    input  logic            fm_ready,
    output logic [OPW-1:0]  fm_OF1,
    output logic [OPW-1:0]  fm_OF2,
    output logic [OPW-1:0]  fm_OF3,
    output logic            busy,
    output logic [7:0]      ch_cnt,
    output logic            err,
    output logic [1:0]      dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [7:0]    CNT_MAX  = 8'(MAX_CH);
    localparam logic [7:0]    CNT_LAST = 8'(MAX_CH - 1);

    state_t        state, state_nx;
    logic          eng_rst_nx, fm_valid_nx, err_nx;
    logic          last_r, last_nx;
    logic [7:0]    ch_cnt_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic          accept;
    logic          acc_clear, acc_load, acc_add;

    assign accept    = (state == IDLE) && ch_valid;
    assign ch_ready  = (state == IDLE);
    assign busy      = (state != IDLE) || (ch_cnt != 8'd0);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            eng_rst  <= 1'b1;
            fm_valid <= 1'b0;
            err      <= 1'b0;
            ch_cnt   <= 8'd0;
            tcnt     <= '0;
            last_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            eng_rst  <= eng_rst_nx;
            fm_valid <= fm_valid_nx;
            err      <= err_nx;
            ch_cnt   <= ch_cnt_nx;
            tcnt     <= tcnt_nx;
            last_r   <= last_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        eng_rst_nx  = eng_rst;
        fm_valid_nx = fm_valid;
        err_nx      = err;
        ch_cnt_nx   = ch_cnt;
        tcnt_nx     = tcnt;
        last_nx     = last_r;
        acc_clear   = 1'b0;
        acc_load    = 1'b0;
        acc_add     = 1'b0;
        case (state)
            IDLE: begin
                if (ch_valid) begin
                    state_nx   = RUN;
                    eng_rst_nx = 1'b0;
                    tcnt_nx    = '0;
                    // the MAX_CH-th channel closes the layer even without ch_last
                    last_nx    = ch_last || (ch_cnt == CNT_LAST);
                end
            end
            RUN: begin
                tcnt_nx = tcnt + 1'b1;
                if (eng_resting) begin
                    state_nx   = ACC;
                    eng_rst_nx = 1'b1;
                end else if (tcnt == TO_LAST) begin
                    state_nx   = IDLE;
                    eng_rst_nx = 1'b1;
                    err_nx     = 1'b1;
                    ch_cnt_nx  = 8'd0;
                    acc_clear  = 1'b1;
                end
            end
            ACC: begin
                acc_load  = (ch_cnt == 8'd0);
                acc_add   = (ch_cnt != 8'd0);
                ch_cnt_nx = (ch_cnt == CNT_MAX) ? ch_cnt : ch_cnt + 8'd1;
                if (last_r) begin
                    state_nx    = OUT;
                    fm_valid_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            OUT: begin
                if (fm_ready) begin
                    state_nx    = IDLE;
                    fm_valid_nx = 1'b0;
                    ch_cnt_nx   = 8'd0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Channel data is held for the engine until the next accepted channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_ipf <= '0;
            eng_K1f <= '0;
            eng_K2f <= '0;
            eng_K3f <= '0;
        end else if (accept) begin
            eng_ipf <= ch_ipf;
            eng_K1f <= ch_K1f;
            eng_K2f <= ch_K2f;
            eng_K3f <= ch_K3f;
        end
    end

    ppfm_sat_accum #(.LANES(OP_SIZE * OP_SIZE)) u_acc1 (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .load  (acc_load),
        .add   (acc_add),
        .din   (eng_IK1),
        .acc   (fm_OF1)
    );

    ppfm_sat_accum #(.LANES(OP_SIZE * OP_SIZE)) u_acc2 (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .load  (acc_load),
        .add   (acc_add),
        .din   (eng_IK2),
        .acc   (fm_OF2)
    );

    ppfm_sat_accum #(.LANES(OP_SIZE * OP_SIZE)) u_acc3 (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .load  (acc_load),
        .add   (acc_add),
        .din   (eng_IK3),
        .acc   (fm_OF3)
    );

endmodule

// File: tb/tb_ppfm_channel_scheduler.sv
// Bench for ppfm_channel_scheduler: bench-side engine stub, directed channels, scoreboard on fm_valid.
module tb_ppfm_channel_scheduler;
    import ppfm_pkg::*;

    localparam int IPW = 16 * 36;
    localparam int KW  = 16 * 9;
    localparam int OPW = 16 * 16;
    localparam int EW  = 3 * OPW + 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ch_valid = 1'b0;
    logic           ch_ready;
    logic           ch_last = 1'b0;
    logic [IPW-1:0] ch_ipf = '0;
    logic [KW-1:0]  ch_K1f = '0, ch_K2f = '0, ch_K3f = '0;
    logic           eng_rst;
    logic [IPW-1:0] eng_ipf;
    logic [KW-1:0]  eng_K1f, eng_K2f, eng_K3f;
    logic           eng_resting = 1'b0;
    logic [OPW-1:0] eng_IK1 = '0, eng_IK2 = '0, eng_IK3 = '0;
    logic           fm_valid;
    logic           fm_ready = 1'b1;
    logic [OPW-1:0] fm_OF1, fm_OF2, fm_OF3;
    logic           busy;
    logic [7:0]     ch_cnt;
    logic           err;
    logic [1:0]     dbg_state;

    ppfm_channel_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .ch_valid    (ch_valid),
        .ch_ready    (ch_ready),
        .ch_last     (ch_last),
        .ch_ipf      (ch_ipf),
        .ch_K1f      (ch_K1f),
        .ch_K2f      (ch_K2f),
        .ch_K3f      (ch_K3f),
        .eng_rst     (eng_rst),
        .eng_ipf     (eng_ipf),
        .eng_K1f     (eng_K1f),
        .eng_K2f     (eng_K2f),
        .eng_K3f     (eng_K3f),
        .eng_resting (eng_resting),
        .eng_IK1     (eng_IK1),
        .eng_IK2     (eng_IK2),
        .eng_IK3     (eng_IK3),
        .fm_valid    (fm_valid),
        .fm_ready    (fm_ready),
        .fm_OF1      (fm_OF1),
        .fm_OF2      (fm_OF2),
        .fm_OF3      (fm_OF3),
        .busy        (busy),
        .ch_cnt      (ch_cnt),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int             n_pass  = 0;
    int             n_total = 0;
    logic [EW-1:0]  exp_q[$];
    logic           stub_hang = 1'b0;
    int             scnt = 0;
    logic [IPW-1:0] ipf_t;
    logic [KW-1:0]  k1_t, k3_t;

    task automatic chk(input string nm, input logic [IPW-1:0] act, input logic [IPW-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    task automatic chkn(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    function automatic logic [OPW-1:0] rep(input logic [15:0] v);
        for (int n = 0; n < 16; n++) rep[16*n +: 16] = v;
    endfunction

    // engine stub: resting after 21 cycles out of reset unless hung
    initial begin : stub
        forever begin
            @(negedge clk);
            if (eng_rst) begin
                eng_resting = 1'b0;
                scnt = 0;
            end else begin
                scnt++;
                if (!stub_hang && scnt >= 21) eng_resting = 1'b1;
            end
        end
    end

    // scoreboard monitor
    initial begin : monitor
        logic [EW-1:0] e;
        logic          vd;
        logic [1:0]    ps;
        vd = 1'b0;
        ps = 2'd0;
        forever begin
            @(negedge clk);
            chkn("ch_ready_vs_state", 32'(ch_ready), 32'(dbg_state == IDLE));
            chkn("eng_rst_vs_state", 32'(eng_rst), 32'(dbg_state != RUN));
            if (fm_valid && !vd) begin
                chkn("fm_valid_after_acc", 32'(ps), 32'(ACC));
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_fm_valid: got fm_valid=1 required no result pending");
                end else begin
                    e = exp_q.pop_front();
                    chk("fm_OF1", IPW'(fm_OF1), IPW'(e[EW-1 -: OPW]));
                    chk("fm_OF2", IPW'(fm_OF2), IPW'(e[EW-1-OPW -: OPW]));
                    chk("fm_OF3", IPW'(fm_OF3), IPW'(e[OPW+7 -: OPW]));
                    chkn("out_ch_cnt", 32'(ch_cnt), 32'(e[7:0]));
                end
            end
            vd = fm_valid;
            ps = dbg_state;
        end
    end

    // driver tasks
    task automatic push_exp(input logic [OPW-1:0] o1, input logic [OPW-1:0] o2,
                            input logic [OPW-1:0] o3, input logic [7:0] c);
        exp_q.push_back({o1, o2, o3, c});
    endtask

    task automatic set_partials(input logic [OPW-1:0] p1, input logic [OPW-1:0] p2,
                                input logic [OPW-1:0] p3);
        eng_IK1 = p1;
        eng_IK2 = p2;
        eng_IK3 = p3;
    endtask

    task automatic send_ch(input logic last);
        int g;
        g = 0;
        @(negedge clk);
        while (!ch_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!ch_ready) begin
            n_total++;
            $display("FAIL send_wait: got ch_ready=0 required 1 within 200 cycles");
        end
        ch_valid = 1'b1;
        ch_last  = last;
        ch_ipf   = ipf_t;
        ch_K1f   = k1_t;
        ch_K2f   = '0;
        ch_K3f   = k3_t;
        @(negedge clk);
        ch_valid = 1'b0;
        ch_last  = 1'b0;
        ch_ipf   = {18{$urandom()}};
        ch_K1f   = {5{$urandom()}};
        ch_K3f   = {5{$urandom()}};
        chkn("accept_to_run", 32'(dbg_state), 32'(RUN));
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (dbg_state != IDLE && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (dbg_state != IDLE) begin
            n_total++;
            $display("FAIL wait_idle: got state=%0d required IDLE within 200 cycles", dbg_state);
        end
    endtask

    task automatic run_ch(input logic last);
        send_ch(last);
        wait_idle();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [OPW-1:0] a1, a2, b1, b2, e1, e2;
        int n;
        ipf_t = rep(16'h4000) | (IPW'(0));
        for (int i = 0; i < 36; i++) ipf_t[16*i +: 16] = 16'h4000;
        k1_t = '0;
        k1_t[16*4 +: 16] = 16'h4000;
        k3_t = '0;
        k3_t[16*4 +: 16] = 16'hC000;

        // reset state
        repeat (3) @(negedge clk);
        chkn("rst_eng_rst", 32'(eng_rst), 1);
        chkn("rst_ch_ready", 32'(ch_ready), 1);
        chkn("rst_fm_valid", 32'(fm_valid), 0);
        chkn("rst_ch_cnt", 32'(ch_cnt), 0);
        chkn("rst_err", 32'(err), 0);
        chkn("rst_busy", 32'(busy), 0);
        chk("rst_fm_OF1", IPW'(fm_OF1), '0);
        chk("rst_eng_ipf", eng_ipf, '0);
        rst = 1'b1;

        // single channel
        set_partials(rep(16'h2000), '0, rep(16'hE000));
        push_exp(rep(16'h2000), '0, rep(16'hE000), 8'd1);
        send_ch(1'b1);
        chk("latched_ipf", eng_ipf, ipf_t);
        chk("latched_K1f", IPW'(eng_K1f), IPW'(k1_t));
        chk("latched_K3f", IPW'(eng_K3f), IPW'(k3_t));
        chkn("busy_in_run", 32'(busy), 1);
        wait_idle();
        chkn("t1_cnt_after", 32'(ch_cnt), 0);

        // two channels
        push_exp(rep(16'h4000), '0, rep(16'hC000), 8'd2);
        run_ch(1'b0);
        chkn("t2_cnt_mid", 32'(ch_cnt), 1);
        chkn("t2_busy_mid", 32'(busy), 1);
        run_ch(1'b1);

        // saturation over three channels
        set_partials(rep(16'h6000), '0, rep(16'hA000));
        push_exp(rep(16'h7FFF), '0, rep(16'h8000), 8'd3);
        run_ch(1'b0);
        run_ch(1'b0);
        chk("t3_OF1_ch2", IPW'(fm_OF1), IPW'(rep(16'h7FFF)));
        chk("t3_OF3_ch2", IPW'(fm_OF3), IPW'(rep(16'h8000)));
        chkn("t3_cnt_ch2", 32'(ch_cnt), 2);
        run_ch(1'b1);

        // per-lane values, saturation only in the upper lanes
        for (int i = 0; i < 16; i++) begin
            a1[16*i +: 16] = 16'(i * 16'h0800);
            a2[16*i +: 16] = 16'(i);
            b1[16*i +: 16] = 16'h4000;
            b2[16*i +: 16] = 16'h0001;
            e1[16*i +: 16] = (i < 8) ? 16'(16'h4000 + i * 16'h0800) : 16'h7FFF;
            e2[16*i +: 16] = 16'(i + 1);
        end
        push_exp(e1, e2, rep(16'h8000), 8'd2);
        set_partials(a1, a2, rep(16'hC000));
        run_ch(1'b0);
        set_partials(b1, b2, rep(16'hC000));
        run_ch(1'b1);

        // engine timeout
        set_partials(rep(16'h2000), '0, rep(16'hE000));
        run_ch(1'b0);
        stub_hang = 1'b1;
        send_ch(1'b1);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chkn("timeout_cycles", 32'(n), 64);
        chkn("timeout_state", 32'(dbg_state), 32'(IDLE));
        chkn("timeout_eng_rst", 32'(eng_rst), 1);
        chkn("timeout_fm_valid", 32'(fm_valid), 0);
        chkn("timeout_ch_cnt", 32'(ch_cnt), 0);
        chk("timeout_OF1_clear", IPW'(fm_OF1), '0);
        stub_hang = 1'b0;
        push_exp(rep(16'h2000), '0, rep(16'hE000), 8'd1);
        run_ch(1'b1);
        chkn("err_sticky", 32'(err), 1);

        // output back-pressure
        fm_ready = 1'b0;
        push_exp(rep(16'h2000), '0, rep(16'hE000), 8'd1);
        send_ch(1'b1);
        n = 0;
        while (!fm_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chkn("hold_fm_valid_seen", 32'(fm_valid), 1);
        repeat (10) begin
            @(negedge clk);
            chkn("hold_fm_valid", 32'(fm_valid), 1);
            chk("hold_OF1", IPW'(fm_OF1), IPW'(rep(16'h2000)));
            chk("hold_OF3", IPW'(fm_OF3), IPW'(rep(16'hE000)));
            chkn("hold_ch_ready", 32'(ch_ready), 0);
        end
        fm_ready = 1'b1;
        @(negedge clk);
        chkn("release_state", 32'(dbg_state), 32'(IDLE));
        chkn("release_fm_valid", 32'(fm_valid), 0);
        chkn("release_ch_cnt", 32'(ch_cnt), 0);
        chk("release_OF1_persist", IPW'(fm_OF1), IPW'(rep(16'h2000)));

        // asynchronous reset mid-RUN
        run_ch(1'b0);
        send_ch(1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chkn("arst_eng_rst", 32'(eng_rst), 1);
        chkn("arst_err", 32'(err), 0);
        chkn("arst_ch_cnt", 32'(ch_cnt), 0);
        chkn("arst_ch_ready", 32'(ch_ready), 1);
        chkn("arst_busy", 32'(busy), 0);
        chk("arst_OF1", IPW'(fm_OF1), '0);
        chk("arst_eng_ipf", eng_ipf, '0);
        @(negedge clk);
        rst = 1'b1;

        // channel limit forces end of layer
        set_partials(rep(16'h0100), '0, rep(16'hFFFF));
        push_exp(rep(16'h1000), '0, rep(16'hFFF0), 8'd16);
        for (int c = 0; c < 16; c++) run_ch(1'b0);
        chkn("maxch_cnt_after", 32'(ch_cnt), 0);

        repeat (5) @(negedge clk);
        chkn("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
